// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep controller: sweep geometry, state
// encoding and the default NOR3 truth table.
package gate_sweep_pkg;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;
  localparam int CNT_W   = 4;
  localparam int ERR_W   = 4;

  localparam logic [NUM_VEC-1:0] NOR3_TT = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } sweep_state_e;

  // Mismatch count saturates at the number of vectors, so it can never wrap.
  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] cnt);
    if (cnt >= ERR_W'(NUM_VEC)) begin
      return ERR_W'(NUM_VEC);
    end
    return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl_settle_counter.sv
// Loadable down-counter timing the settle window between applying a
// vector and sampling the gate output.
module settle_counter
  import gate_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Steps a 3-input gate through all eight input vectors, waits for the
// output to settle, and compares each sample against TRUTH_TABLE.
//
// state  | meaning
// IDLE   | gate inputs parked at 000, results held, waiting for start
// APPLY  | drive current vector onto gate inputs, arm settle counter
// WAIT   | hold vector for SETTLE_CYC cycles
// SAMPLE | compare gate_q with expected bit, record mismatch, advance
// DONE   | one-cycle done pulse, then back to IDLE
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] TRUTH_TABLE = NOR3_TT,
  parameter int unsigned        SETTLE_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               gate_q,
  output logic               gate_x,
  output logic               gate_y,
  output logic               gate_z,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] fail_map,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_APPLY  = ST_APPLY;
  localparam logic [2:0] S_WAIT   = ST_WAIT;
  localparam logic [2:0] S_SAMPLE = ST_SAMPLE;
  localparam logic [2:0] S_DONE   = ST_DONE;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VEC - 1);

  logic [2:0]       state;
  logic [VEC_W-1:0] idx;
  logic [VEC_W-1:0] gate_vec;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;
  logic             abort_run;

  assign abort_run = abort && (state != S_IDLE);

  // gate_q only reaches registers, never an output directly.
  assign mismatch = (gate_q != TRUTH_TABLE[idx]);
  assign err_next = mismatch ? err_inc(err_cnt) : err_cnt;

  assign cnt_load = (state == S_APPLY) && !abort_run;
  assign cnt_dec  = (state == S_WAIT) && !abort_run;

  settle_counter u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      gate_vec <= '0;
      pass     <= 1'b0;
      fail_map <= '0;
      err_cnt  <= '0;
    end else if (abort_run) begin
      // Partial fail_map/err_cnt are kept for post-mortem inspection.
      state    <= S_IDLE;
      gate_vec <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state    <= S_APPLY;
            idx      <= '0;
            pass     <= 1'b0;
            fail_map <= '0;
            err_cnt  <= '0;
          end
        end
        S_APPLY: begin
          gate_vec <= idx;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_zero) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (mismatch) begin
            fail_map[idx] <= 1'b1;
          end
          err_cnt <= err_next;
          if (idx == LAST_IDX) begin
            state    <= S_DONE;
            pass     <= (err_next == '0);
            gate_vec <= '0;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_APPLY;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          gate_vec <= '0;
        end
      endcase
    end
  end

  assign {gate_x, gate_y, gate_z} = gate_vec;
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: a behavioural gate model with
// injectable per-vector faults, compared against expected sweep results.
module tb_gate_sweep_ctrl;

  localparam int SETTLE = 2;
  localparam int K      = SETTLE + 2;
  localparam int NV     = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       gate_q;
  logic       gate_x, gate_y, gate_z;
  logic       busy, done, pass;
  logic [7:0] fail_map;
  logic [3:0] err_cnt;

  logic [7:0] ref_tt;
  logic [7:0] model_out;

  int checks = 0;
  int errors = 0;

  gate_sweep_ctrl #(
    .TRUTH_TABLE (8'h01),
    .SETTLE_CYC  (SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .gate_q   (gate_q),
    .gate_x   (gate_x),
    .gate_y   (gate_y),
    .gate_z   (gate_z),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_map (fail_map),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Gate model: per-vector output table; faults are bits differing from NOR3.
  assign gate_q = model_out[{gate_x, gate_y, gate_z}];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_gates"}, 32'({gate_x, gate_y, gate_z}), 32'd0);
  endtask

  task automatic start_sweep();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
  endtask

  // Runs edges 1..8*K+1 after an accepted start and checks the result.
  task automatic run_body(input string tag);
    logic [7:0] exp_map;
    exp_map = model_out ^ ref_tt;
    for (int e = 1; e <= K * NV; e++) begin
      tick();
      if (e % K == 2) check({tag, "_vec"}, 32'({gate_x, gate_y, gate_z}), 32'(e / K));
      check({tag, "_done"}, 32'(done), 32'(e == K * NV));
    end
    tick();
    check_idle_zero({tag, "_end"});
    check({tag, "_pass"}, 32'(pass), 32'(exp_map == 8'h00));
    check({tag, "_map"}, 32'(fail_map), 32'(exp_map));
    check({tag, "_err"}, 32'(err_cnt), 32'($countones(exp_map)));
  endtask

  initial begin
    int n;
    int done_cnt;
    logic [7:0] part;

    for (int i = 0; i < NV; i++) ref_tt[i] = (i == 0);
    model_out = ref_tt;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #2;
    check_idle_zero("reset");
    check("reset_pass", 32'(pass), 32'd0);
    check("reset_map", 32'(fail_map), 32'd0);
    check("reset_err", 32'(err_cnt), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    model_out = ref_tt;
    start_sweep();
    run_body("ideal");

    model_out = 8'h00;
    start_sweep();
    run_body("stuck0");

    model_out = 8'hFF;
    start_sweep();
    run_body("stuck1");

    repeat (3) begin
      model_out = 8'($urandom);
      start_sweep();
      run_body("rand");
    end

    // Abort during vector 4 WAIT: results reflect vectors 0..3 only.
    model_out = 8'($urandom) | 8'h0A;
    part = (model_out ^ ref_tt) & 8'h0F;
    start_sweep();
    for (int e = 1; e <= 4 * K + 2; e++) tick();
    check("abort_pre_vec", 32'({gate_x, gate_y, gate_z}), 32'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_zero("abort");
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_map", 32'(fail_map), 32'(part));
    check("abort_err", 32'(err_cnt), 32'($countones(part)));
    done_cnt = 0;
    repeat (K * NV) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);

    // Asynchronous reset mid-sweep, then a clean sweep right after release.
    model_out = 8'hFF;
    start_sweep();
    n = $urandom_range(3, 30);
    repeat (n) tick();
    #2 rst_n = 1'b0;
    #1;
    check_idle_zero("arst");
    check("arst_pass", 32'(pass), 32'd0);
    check("arst_map", 32'(fail_map), 32'd0);
    check("arst_err", 32'(err_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
    model_out = ref_tt;
    start_sweep();
    run_body("post_rst");

    // Held start: one full sweep, re-trigger the cycle after returning to IDLE.
    start = 1'b1;
    tick();
    done_cnt = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (done) done_cnt++;
      if (e == K * NV + 1) check("held_idle", 32'(busy), 32'd0);
      if (e == K * NV + 2) check("held_retrig", 32'(busy), 32'd1);
    end
    check("held_one_done", 32'(done_cnt), 32'd1);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("held_abort_busy", 32'(busy), 32'd0);

    // start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    check("both_busy0", 32'(busy), 32'd0);
    tick();
    check("both_busy1", 32'(busy), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 Parameter TRUTH_TABLE, default 8'h01, is the expected gate output per input vector; bit i applies when {gate_x,gate_y,gate_z}=i, with gate_x as MSB. The default is 3-input NOR.
REQ-002 Parameter SETTLE_CYC, default 2, is the number of wait cycles between applying a vector and sampling; legal range 1..15.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  request to begin a sweep; honoured only in IDLE.
REQ-006 abort  in  1  cancels a running sweep.
REQ-007 gate_q  in  1  output of the gate under control.
REQ-008 gate_x, gate_y, gate_z  out  1 each  registered gate inputs.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 done  out  1  one-cycle pulse when a sweep completes.
REQ-011 pass  out  1  set when a completed sweep had zero mismatches.
REQ-012 fail_map  out  8  bit i set if vector i mismatched.
REQ-013 err_cnt  out  4  mismatch count, range 0..8.

Function
REQ-014 States: IDLE, APPLY, WAIT, SAMPLE, DONE; 3-bit vector index idx.
REQ-015 IDLE with start=1 and abort=0 → APPLY; on the same edge: idx=0, fail_map=0, err_cnt=0, pass=0.
REQ-016 APPLY lasts 1 cycle: {gate_x,gate_y,gate_z} loaded with idx; settle counter loaded with SETTLE_CYC-1; then → WAIT.
REQ-017 WAIT lasts exactly SETTLE_CYC cycles (counter decrements; → SAMPLE when zero); gate inputs stable throughout.
REQ-018 SAMPLE lasts 1 cycle: gate_q compared with TRUTH_TABLE[idx]; on mismatch fail_map[idx]=1 and err_cnt+1.
REQ-019 SAMPLE exit: idx≠7 → idx+1, → APPLY; idx==7 → DONE, with pass loaded as (final err_cnt == 0), including the current sample.
REQ-020 DONE lasts 1 cycle with done=1, then → IDLE.
REQ-021 Per-vector latency is SETTLE_CYC+2 cycles. done is high in the cycle after edge 8*(SETTLE_CYC+2) counted from the edge that accepts start (edge 32 at default).
REQ-022 gate_q is sampled only in SAMPLE; it is ignored in all other states.
REQ-023 pass, fail_map and err_cnt are held from DONE until the next accepted start.
REQ-024 start while busy is ignored; a held start re-triggers only once the block is back in IDLE.
REQ-025 abort=1 in any non-IDLE state → IDLE on the next edge: gate_x/y/z=0, pass=0, no done pulse, fail_map and err_cnt hold partial results.
REQ-026 abort has priority over start; start and abort together in IDLE leave the block in IDLE.
REQ-027 gate_x/y/z are 0 in IDLE, after abort, and after DONE.
REQ-028 err_cnt never wraps; maximum value is 8.

Reset
REQ-029 rst_n=0 immediately forces state=IDLE, idx=0, settle counter=0, and all outputs 0, regardless of clk.
REQ-030 Reset asserted mid-sweep discards the sweep; no done pulse follows.
REQ-031 The first start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package gate_sweep_pkg holds the state enum, VEC_W=3, NUM_VEC=8, and NOR3_TT=8'h01.
REQ-033 One sub-module, settle_counter, is a 4-bit loadable down-counter with async active-low reset and a zero flag; it is instantiated once.
REQ-034 gate_sweep_ctrl contains no combinational path from gate_q to any output.

Verification
REQ-035 Ideal NOR3 model on gate_q, start pulse → gate inputs step 000..111, done at edge 32, pass=1, fail_map=8'h00, err_cnt=0.
REQ-036 gate_q stuck at 0 → fail_map=8'h01, err_cnt=1, pass=0.
REQ-037 gate_q stuck at 1 → fail_map=8'hFE, err_cnt=7, pass=0.
REQ-038 abort during vector 4 WAIT → busy=0 next cycle, gate inputs 000, no done, pass=0, fail_map bits [3:0] reflect samples taken.
REQ-039 rst_n pulsed low mid-sweep (no clk edge) → all outputs 0 at once; a subsequent start runs a full clean sweep.
REQ-040 start held high for 40 cycles → exactly one sweep, then a second sweep begins the cycle after IDLE; start+abort in IDLE → busy stays 0.
